ecdsa_share_combiner: RTL
=========================

Name: ecdsa_share_combiner

Overview:
- Downstream of the ECDSA signing core when it runs in partial (threshold) mode.
- Collects partial signatures {r, s_i} from distinct key shards over one session and checks that all shares agree on r and on the message hash.
- Sums the s_i modulo the curve order and emits one combined 256-bit signature {r, s} once THRESHOLD distinct shares have been accepted.
- Rejects duplicate shard IDs; flags inconsistent shares as a session error.

Parameters:
- THRESHOLD, 3: number of distinct shares required, legal range 2..16.
- ORDER_N, 128'hFFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B: modulus for s accumulation. Must be nonzero and below 2^128.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- abort  input  1  synchronous session clear, highest priority after reset.
- share_valid  input  1  partial signature present.
- share_ready  output  1  combiner can accept a share this cycle.
- share_sig  input  256  partial signature: [255:128] r, [127:0] s_i.
- share_hash  input  128  message hash the share was computed over.
- share_id  input  4  shard index, 0..15.
- sig_valid  output  1  combined signature available.
- sig_ready  input  1  consumer takes the combined signature.
- sig_out  output  256  combined signature {r, s}.
- share_count  output  5  distinct shares accepted this session.
- dup_reject  output  1  one-cycle pulse when a duplicate-ID share is dropped.
- error  output  1  session error, sticky until abort.
- err_code  output  2  01 r mismatch, 10 hash mismatch, 11 s_i >= ORDER_N, 00 none.

Behaviour:
- Reset (reset_n low, asynchronous) forces state IDLE and clears:
  - share_ready=0 for the reset cycle, then 1 in IDLE;
  - sig_valid=0, sig_out=0, share_count=0, dup_reject=0, error=0, err_code=0;
  - accumulator, latched r/hash, and the 16-bit seen-ID bitmap.
- Handshake: a share is accepted on a rising edge with share_valid && share_ready.
  - share_ready=1 only in IDLE and COLLECT.
  - Share inputs are sampled only on acceptance.
- States:
  - IDLE. On accept: if s_i >= ORDER_N go to ERROR (code 11). Otherwise latch r, latch hash, set acc=s_i, set bitmap[id], count=1, then COLLECT.
  - COLLECT. On accept, checks run in this priority order:
    - bitmap[id] already set: drop the share, pulse dup_reject, no state change.
    - r != latched r: ERROR, code 01.
    - hash != latched hash: ERROR, code 10.
    - s_i >= ORDER_N: ERROR, code 11.
    - Otherwise: register s_i, set bitmap[id], go to ADD.
  - ADD (exactly 1 cycle, share_ready=0):
    - sum = acc + s_i in 129 bits; acc = (sum >= ORDER_N) ? sum - ORDER_N : sum.
    - count += 1.
    - If the new count == THRESHOLD go to DONE, else return to COLLECT.
  - DONE:
    - sig_out = {r, acc}, sig_valid=1, both held stable until sig_ready.
    - On sig_valid && sig_ready: sig_valid=0, session cleared (count, bitmap, acc, latches), go to IDLE. share_ready is 1 on the next cycle.
  - ERROR: share_ready=0, error=1, err_code held. Leaves only on abort or reset.
- Latency: from the accept edge of the THRESHOLD-th share to sig_valid high is 2 cycles (ADD, then DONE register). Accepted-share throughput is at most one per 2 cycles after the first.
- abort = 1 in any state clears the session and returns to IDLE on the next edge. Any pending sig_valid is dropped, error and err_code are cleared, and no dup_reject pulse is produced.
- Simultaneous abort and share accept: abort wins and the share is discarded.
- share_count saturates only by construction and never exceeds THRESHOLD.
- err_code is 00 whenever error=0.
- reset_n asserted mid-ADD or mid-DONE discards everything immediately (asynchronous).

Test Plan:
- THRESHOLD=3, N=ORDER_N: shares id 0,1,2 with r=R, s=5,7,9 -> sig_valid 2 cycles after the third accept, sig_out={R,21}, share_count=3.
- Wrap: s = N-1, N-1, 3 -> combined s = 1. Checks both modular reductions.
- Duplicate: ids 4,4,6,9 -> dup_reject pulses once at the second id 4, and sig_valid comes after id 9 only.
- Mismatch: second share r=R+1 -> error=1, err_code=01, share_ready=0. Then abort -> IDLE, error=0, share_count=0.
- sig_ready held low 10 cycles -> sig_valid and sig_out stable throughout. After sig_ready, a new session starts cleanly with a reused id 0.
- reset_n pulsed low in ADD -> all outputs zero asynchronously, and share_ready=1 on the first edge after release.

Source files
------------

// File: rtl/ecdsa_share_combiner.sv
// Threshold ECDSA share combiner: gathers distinct partial signatures,
// checks r/hash consistency and sums the s_i modulo the curve order.
module ecdsa_share_combiner #(
    parameter int unsigned  THRESHOLD = 3,
    parameter logic [127:0] ORDER_N   = 128'hFFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         abort,
    input  logic         share_valid,
    output logic         share_ready,
    input  logic [255:0] share_sig,
    input  logic [127:0] share_hash,
    input  logic [3:0]   share_id,
    output logic         sig_valid,
    input  logic         sig_ready,
    output logic [255:0] sig_out,
    output logic [4:0]   share_count,
    output logic         dup_reject,
    output logic         error,
    output logic [1:0]   err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ADD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [4:0] THR = 5'(THRESHOLD);

    state_t       state_q;
    logic         ready_q;
    logic [127:0] r_q;
    logic [127:0] hash_q;
    logic [127:0] acc_q;
    logic [127:0] si_q;
    logic [15:0]  seen_q;
    logic [4:0]   count_q;
    logic         sig_valid_q;
    logic [255:0] sig_out_q;
    logic         dup_q;
    logic         err_q;
    logic [1:0]   code_q;

    logic         accept;
    logic [127:0] r_in;
    logic [127:0] s_in;
    logic [15:0]  id_bit;
    logic         s_ge_n;
    logic [128:0] sum;
    logic [127:0] acc_d;
    logic [4:0]   count_d;

    assign accept  = share_valid && ready_q;
    assign r_in    = share_sig[255:128];
    assign s_in    = share_sig[127:0];
    assign id_bit  = 16'd1 << share_id;
    assign s_ge_n  = s_in >= ORDER_N;
    assign count_d = count_q + 5'd1;

    // Both operands are already reduced, so one conditional subtract suffices.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, si_q};
        acc_d = sum[127:0];
        if (sum >= {1'b0, ORDER_N}) begin
            acc_d = 128'(sum - {1'b0, ORDER_N});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            r_q         <= '0;
            hash_q      <= '0;
            acc_q       <= '0;
            si_q        <= '0;
            seen_q      <= '0;
            count_q     <= '0;
            sig_valid_q <= 1'b0;
            sig_out_q   <= '0;
            dup_q       <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
        end else begin
            dup_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                ready_q     <= 1'b1;
                r_q         <= '0;
                hash_q      <= '0;
                acc_q       <= '0;
                si_q        <= '0;
                seen_q      <= '0;
                count_q     <= '0;
                sig_valid_q <= 1'b0;
                sig_out_q   <= '0;
                err_q       <= 1'b0;
                code_q      <= 2'b00;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            if (s_ge_n) begin
                                state_q <= S_ERROR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                                code_q  <= 2'b11;
                            end else begin
                                r_q     <= r_in;
                                hash_q  <= share_hash;
                                acc_q   <= s_in;
                                seen_q  <= id_bit;
                                count_q <= 5'd1;
                                state_q <= S_COLLECT;
                            end
                        end
                    end
                    S_COLLECT: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            if ((seen_q & id_bit) != '0) begin
                                dup_q <= 1'b1;
                            end else if (r_in != r_q) begin
                                state_q <= S_ERROR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                                code_q  <= 2'b01;
                            end else if (share_hash != hash_q) begin
                                state_q <= S_ERROR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                                code_q  <= 2'b10;
                            end else if (s_ge_n) begin
                                state_q <= S_ERROR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                                code_q  <= 2'b11;
                            end else begin
                                si_q    <= s_in;
                                seen_q  <= seen_q | id_bit;
                                state_q <= S_ADD;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    S_ADD: begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (count_d == THR) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_COLLECT;
                            ready_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        ready_q <= 1'b0;
                        if (!sig_valid_q) begin
                            sig_valid_q <= 1'b1;
                            sig_out_q   <= {r_q, acc_q};
                        end else if (sig_ready) begin
                            state_q     <= S_IDLE;
                            ready_q     <= 1'b1;
                            r_q         <= '0;
                            hash_q      <= '0;
                            acc_q       <= '0;
                            si_q        <= '0;
                            seen_q      <= '0;
                            count_q     <= '0;
                            sig_valid_q <= 1'b0;
                            sig_out_q   <= '0;
                        end
                    end
                    S_ERROR: begin
                        ready_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign share_ready = ready_q;
    assign sig_valid   = sig_valid_q;
    assign sig_out     = sig_out_q;
    assign share_count = count_q;
    assign dup_reject  = dup_q;
    assign error       = err_q;
    assign err_code    = code_q;

endmodule
